// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmit line among NUM_REQ byte requesters.
// A rotating-priority arbiter picks one pending requester, latches its byte
// (plus optional parity) and serialises start, data LSB-first, parity, stop.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,   // 2..8
  parameter int CLK_DIV = 16,  // clk cycles per UART bit, >= 2
  parameter int PAR_EN  = 1    // 1: frame carries a parity bit
) (
  input  logic                 clk,
  input  logic                 reset,    // asynchronous, active-low
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  input  logic                 p_sel,    // 0: even parity, 1: odd parity
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 tx
);

  localparam int FRAME_BITS = 10 + PAR_EN;
  // The start bit is driven directly at grant, so only the rest is stored.
  localparam int PAY_W      = FRAME_BITS - 1;
  localparam int BAUD_W     = $clog2(CLK_DIV);
  localparam int ID_W       = $clog2(NUM_REQ);

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [3:0]          bit_q;
  logic [PAY_W-1:0]    shift_q;
  logic [ID_W-1:0]     last_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [2:0]          grant_q;
  logic                busy_q;
  logic                tx_q;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W:0]       scan;
  logic [7:0]          sel_byte;
  logic                par;
  logic [PAY_W-1:0]    payload;

  // Rotating-priority search: first pending request after the last grant.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips the write infers a latch.
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan = {1'b0, last_q} + (ID_W+1)'(i);
      if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
      if (!win_found && req[scan[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[ID_W-1:0];
      end
    end
  end

  assign sel_byte = data[{win_idx, 3'b000} +: 8];
  assign par      = p_sel ? ~^sel_byte : ^sel_byte;

  generate
    if (PAR_EN != 0) begin : g_par
      assign payload = {1'b1, par, sel_byte};
    end else begin : g_nopar
      assign payload = {1'b1, sel_byte};
    end
  endgenerate

  // Scheduler / serialiser FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      last_q  <= ID_W'(NUM_REQ - 1);
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values held before this edge, independent of statement order.
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (win_found) begin
            shift_q <= payload;
            last_q  <= win_idx;
            grant_q <= 3'(win_idx);
            ack_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (baud_q == BAUD_W'(CLK_DIV - 1)) begin
            baud_q <= '0;
            if (bit_q == 4'(FRAME_BITS - 1)) begin
              // Stop bit has been held a full bit time.
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
              bit_q   <= '0;
            end else begin
              bit_q   <= bit_q + 4'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b1, shift_q[PAY_W-1:1]};
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: a parity-enabled instance checked by a frame
// scoreboard, and a no-parity instance checked by a hand-written sequence.
module tb_uart_tx_sched;

  localparam int NR = 4;
  localparam int CD = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_a = '0, req_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        p_sel = 1'b0;
  logic [3:0]  ack_a, ack_b;
  logic [2:0]  gid_a, gid_b;
  logic        busy_a, busy_b, tx_a, tx_b;

  uart_tx_sched #(.NUM_REQ(NR), .CLK_DIV(CD), .PAR_EN(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .data(data_a), .p_sel(p_sel),
    .ack(ack_a), .grant_id(gid_a), .busy(busy_a), .tx(tx_a));

  uart_tx_sched #(.NUM_REQ(NR), .CLK_DIV(CD), .PAR_EN(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .data(data_b), .p_sel(p_sel),
    .ack(ack_b), .grant_id(gid_b), .busy(busy_b), .tx(tx_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [10:0] frame;
  } exp_t;

  exp_t sb_q[$];
  int   frames_pushed = 0;
  int   frames_done   = 0;

  // Expected 11-bit frame, index 0 = first bit on the line.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic ps);
    logic odd_ones;
    logic p;
    odd_ones = ($countones(d) % 2) == 1;
    p = ps ? !odd_ones : odd_ones;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic push_exp(input int id, input logic [7:0] d, input logic ps);
    exp_t e;
    e.id = id;
    e.frame = mk_frame(d, ps);
    sb_q.push_back(e);
    frames_pushed++;
  endtask

  // Frame monitor for dut_a: sample each bit mid-period, compare to scoreboard.
  initial begin : mon
    int          id;
    logic [10:0] cap;
    bit          aborted;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset && ack_a != 4'd0) begin
        check("ack_onehot", 32'($onehot(ack_a)), 1);
        id = 0;
        for (int i = 0; i < NR; i++) if (ack_a[i]) id = i;
        check("grant_id", 32'(gid_a), id);
        check("busy_at_grant", 32'(busy_a), 1);
        cap     = '0;
        cap[0]  = tx_a;
        aborted = 1'b0;
        for (int j = 1; j < 11; j++) begin
          for (int c = 0; c < CD; c++) begin
            @(negedge clk);
            if (!reset) aborted = 1'b1;
            if (j == 1 && c == 0 && !aborted) check("ack_pulse_width", 32'(ack_a), 0);
          end
          if (aborted) break;
          cap[j] = tx_a;
        end
        if (!aborted) begin
          repeat (CD - 1) @(negedge clk);
          check("busy_last_clk", 32'(busy_a), 1);
          @(negedge clk);
          check("busy_after_frame", 32'(busy_a), 0);
          check("tx_idle_after_frame", 32'(tx_a), 1);
        end
        check("frame_expected", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          if (!aborted) begin
            check("frame_id", id, e.id);
            check("frame_bits", 32'(cap), 32'(e.frame));
          end
        end
        frames_done++;
      end
    end
  end

  task automatic wait_ack_a(input int k, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack_a[k] && cyc < budget);
    if (!ack_a[k]) check($sformatf("ack_wait_%0d", k), 32'(ack_a[k]), 1);
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (busy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) check("idle_wait", 32'(busy_a), 0);
  endtask

  task automatic wait_frames();
    int n;
    n = 0;
    while (frames_done < frames_pushed && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < frames_pushed) check("frames_done", frames_done, frames_pushed);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_tx", 32'(tx_a), 1);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ack", 32'(ack_a), 0);
    check("rst_grant_id", 32'(gid_a), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       ps;
  } vec_t;

  vec_t        vecs[6];
  int          cyc;
  int          exp_k;
  logic [9:0]  cap_b;

  initial begin : main
    vecs[0] = '{k: 0, d: 8'h55, ps: 1'b0};
    vecs[1] = '{k: 0, d: 8'h00, ps: 1'b1};
    vecs[2] = '{k: 1, d: 8'hA5, ps: 1'b0};
    vecs[3] = '{k: 2, d: 8'hFF, ps: 1'b1};
    vecs[4] = '{k: 3, d: 8'h80, ps: 1'b0};
    vecs[5] = '{k: 1, d: 8'h3C, ps: 1'b1};

    // Power-on reset.
    #23;
    check("por_tx", 32'(tx_a), 1);
    check("por_busy", 32'(busy_a), 0);
    check("por_ack", 32'(ack_a), 0);
    check("por_grant_id", 32'(gid_a), 0);
    check("por_tx_b", 32'(tx_b), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single-requester frames; p_sel flipped mid-frame must not matter.
    for (int v = 0; v < 6; v++) begin
      wait_idle_a();
      req_a[vecs[v].k] = 1'b1;
      data_a[8*vecs[v].k +: 8] = vecs[v].d;
      p_sel = vecs[v].ps;
      push_exp(vecs[v].k, vecs[v].d, vecs[v].ps);
      wait_ack_a(vecs[v].k, 100, cyc);
      check("ack_latency", cyc, 1);
      check("ack_vector", 32'(ack_a), 32'(1) << vecs[v].k);
      check("start_bit", 32'(tx_a), 0);
      req_a[vecs[v].k] = 1'b0;
      p_sel = ~vecs[v].ps;
    end
    wait_frames();

    // No-parity instance: 10-bit frame, stop right after data bit 7.
    @(negedge clk);
    req_b[0] = 1'b1;
    data_b[7:0] = 8'hA5;
    @(negedge clk);
    check("b_ack", 32'(ack_b), 1);
    req_b[0] = 1'b0;
    cap_b[0] = tx_b;
    for (int j = 1; j < 10; j++) begin
      repeat (CD) @(negedge clk);
      cap_b[j] = tx_b;
    end
    check("b_frame_bits", 32'(cap_b), 32'({1'b1, 8'hA5, 1'b0}));
    repeat (CD - 1) @(negedge clk);
    check("b_busy_last_clk", 32'(busy_b), 1);
    @(negedge clk);
    check("b_busy_after_frame", 32'(busy_b), 0);
    check("b_tx_idle", 32'(tx_b), 1);

    // All four requesting from reset: order 0,1,2,3, 45 clks apart.
    p_sel = 1'b0;
    data_a = {8'h44, 8'h33, 8'h22, 8'h11};
    req_a  = 4'hF;
    for (int k = 0; k < 4; k++) push_exp(k, data_a[8*k +: 8], 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_ack_a(k, 100, cyc);
      check($sformatf("all_req_spacing_%0d", k), cyc, (k == 0) ? 1 : 45);
      req_a[k] = 1'b0;
    end
    wait_frames();

    // req0 and req2 held continuously with fresh bytes: 0,2,0,2,0,2.
    p_sel  = 1'b1;
    data_a = {8'h00, 8'h22, 8'h00, 8'h11};
    req_a  = 4'b0101;
    push_exp(0, 8'h11, 1'b1);
    push_exp(2, 8'h22, 1'b1);
    do_reset();
    for (int n = 0; n < 6; n++) begin
      exp_k = (n % 2 == 0) ? 0 : 2;
      wait_ack_a(exp_k, 100, cyc);
      check($sformatf("alt_spacing_%0d", n), cyc, (n == 0) ? 1 : 45);
      if (n < 4) begin
        data_a[8*exp_k +: 8] = 8'h30 + 8'(n);
        push_exp(exp_k, 8'h30 + 8'(n), 1'b1);
      end else begin
        req_a[exp_k] = 1'b0;
      end
    end
    wait_frames();

    // Reset 20 clks into a frame aborts it at once; then req1 alone.
    do_reset();
    p_sel = 1'b0;
    data_a[7:0] = 8'h00;
    req_a[0] = 1'b1;
    push_exp(0, 8'h00, 1'b0);
    wait_ack_a(0, 100, cyc);
    req_a[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("tx_before_abort", 32'(tx_a), 0);
    reset = 1'b0;
    #1;
    check("abort_tx", 32'(tx_a), 1);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_ack", 32'(ack_a), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req_a[1] = 1'b1;
    data_a[15:8] = 8'hC3;
    p_sel = 1'b1;
    push_exp(1, 8'hC3, 1'b1);
    wait_ack_a(1, 100, cyc);
    check("post_abort_latency", cyc, 1);
    req_a[1] = 1'b0;
    wait_frames();

    // req3 pulsed for one clk during SEND is never served.
    p_sel = 1'b0;
    data_a[23:16] = 8'h96;
    req_a[2] = 1'b1;
    push_exp(2, 8'h96, 1'b0);
    wait_ack_a(2, 100, cyc);
    req_a[2] = 1'b0;
    repeat (10) @(negedge clk);
    req_a[3] = 1'b1;
    data_a[31:24] = 8'hFF;
    @(negedge clk);
    req_a[3] = 1'b0;
    wait_frames();
    for (int n = 0; n < 6; n++) begin
      repeat (10) @(negedge clk);
      check("idle_tx", 32'(tx_a), 1);
      check("idle_busy", 32'(busy_a), 0);
    end

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
